// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 2x line-pair scaler.
// Generates 640x480 VGA timing, drives the scaler read address and restart
// requests, frames the 512-wide scaled image with a border colour and
// optionally darkens odd output lines.
//
// Ports:
//   clk          pixel clock, one pixel per cycle
//   reset        synchronous reset, active-high
//   scanlines    1 = halve intensity on odd output lines
//   scaler_pixel scaler output {b,g,r}, valid one cycle after read_x
//   read_x       scaler read address {line-in-pair, x[8:0]} (combinational)
//   reset_line   scaler line restart request (registered)
//   reset_frame  scaler frame restart request (registered)
//   vga_r/g/b    5-bit colour channels
//   vga_hs/vs    active-low syncs
//   vga_de       visible-area data enable
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_LEFT = 64,
  parameter logic [14:0] BORDER   = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scanlines,
  input  logic [14:0] scaler_pixel,
  output logic [9:0]  read_x,
  output logic        reset_line,
  output logic        reset_frame,
  output logic [4:0]  vga_r,
  output logic [4:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de
);

  localparam int unsigned CW       = 10;
  localparam int unsigned IMG_W    = 512;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;

  // stage 1: region flags aligned with the scaler's registered pixel
  logic vis1_q, img1_q, hs1_q, vs1_q, odd1_q;
  // stage 2: output pins
  logic        hs2_q, vs2_q, de2_q;
  logic [14:0] rgb2_q;
  logic        rl_q, rf_q;

  logic        visible_c, img_c, hs_n_c, vs_n_c, rl_c, rf_c;
  logic [8:0]  x_off_c;
  logic [14:0] base_c, col_c;

  // raster counters: hcnt wraps every line, vcnt advances on each hcnt wrap
  always_comb begin
    hcnt_d = hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == CW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == CW'(V_TOTAL - 1)) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + CW'(1);
      end
    end
  end

  // region decode at the current counter state
  always_comb begin
    visible_c = (hcnt_q < CW'(H_ACTIVE)) && (vcnt_q < CW'(V_ACTIVE));
    img_c     = visible_c && (hcnt_q >= CW'(IMG_LEFT)) && (hcnt_q < CW'(IMG_LEFT + IMG_W));
    hs_n_c    = !((hcnt_q >= CW'(HS_START)) && (hcnt_q < CW'(HS_END)));
    vs_n_c    = !((vcnt_q >= CW'(VS_START)) && (vcnt_q < CW'(VS_END)));
    // line restart spans the blanking of every odd visible line, plus the
    // last line of the frame to prime the scaler for line 0
    rl_c      = (hcnt_q >= CW'(H_ACTIVE)) &&
                ((vcnt_q[0] && (vcnt_q < CW'(V_ACTIVE))) || (vcnt_q == CW'(V_TOTAL - 1)));
    rf_c      = (vcnt_q >= CW'(VS_START)) && (vcnt_q < CW'(VS_END));
  end

  // scaler read address, parked at x=0 outside the image window
  assign x_off_c = 9'(hcnt_q - CW'(IMG_LEFT));
  assign read_x  = {vcnt_q[0], img_c ? x_off_c : 9'd0};

  // colour select, then optional scanline halving (zero-filled per channel)
  always_comb begin
    base_c = 15'd0;
    if (img1_q) begin
      base_c = scaler_pixel;
    end else if (vis1_q) begin
      base_c = BORDER;
    end
    col_c = base_c;
    if (scanlines && odd1_q && vis1_q) begin
      col_c = {1'b0, base_c[14:11], 1'b0, base_c[9:6], 1'b0, base_c[4:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      vis1_q <= 1'b0;
      img1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      odd1_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      de2_q  <= 1'b0;
      rgb2_q <= 15'd0;
      rl_q   <= 1'b0;
      rf_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      vis1_q <= visible_c;
      img1_q <= img_c;
      hs1_q  <= hs_n_c;
      vs1_q  <= vs_n_c;
      odd1_q <= vcnt_q[0];
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      de2_q  <= vis1_q;
      rgb2_q <= col_c;
      rl_q   <= rl_c;
      rf_q   <= rf_c;
    end
  end

  assign vga_r       = rgb2_q[4:0];
  assign vga_g       = rgb2_q[9:5];
  assign vga_b       = rgb2_q[14:10];
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_de      = de2_q;
  assign reset_line  = rl_q;
  assign reset_frame = rf_q;

endmodule
